// File: rtl/signed_accum_dump.sv
// Signed accumulate-and-dump: sums N_ACC valid samples at full precision and
// emits the sum (MODE 0) or the floor-average (MODE 1) with a one-cycle pulse.
module signed_accum_dump #(
  parameter int WLin  = 4,
  parameter int N_ACC = 4,
  parameter int MODE  = 0,
  parameter int WLout = WLin + $clog2(N_ACC),
  parameter int WLcnt = (N_ACC > 1) ? $clog2(N_ACC) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  input  logic signed [WLin-1:0]  in_data,
  output logic                    out_valid,
  output logic signed [WLout-1:0] out_data,
  output logic        [WLcnt-1:0] acc_count
);

  localparam int unsigned SHIFT = $clog2(N_ACC);
  localparam logic [WLcnt-1:0] LAST = WLcnt'(N_ACC - 1);

  if (MODE == 1 && (N_ACC & (N_ACC - 1)) != 0) begin : g_mode_check
    $error("signed_accum_dump: MODE=1 requires N_ACC to be a power of 2");
  end

  logic signed [WLout-1:0] acc_q, acc_d;
  logic        [WLcnt-1:0] count_q, count_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [WLout-1:0] out_data_q, out_data_d;

  logic signed [WLout-1:0] sample_ext;
  logic signed [WLout-1:0] sum_c;
  logic signed [WLout-1:0] result_c;

  assign sample_ext = WLout'(in_data);
  assign sum_c      = acc_q + sample_ext;
  // Arithmetic shift gives floor (toward -inf) rounding for the average.
  assign result_c   = (MODE == 1) ? (sum_c >>> SHIFT) : sum_c;

  // Next-state: clear beats dump beats accumulate; with N_ACC=1 every valid
  // sample dumps, including one that arrives with clr.
  always_comb begin
    acc_d       = acc_q;
    count_d     = count_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    if (clr && in_valid && (N_ACC > 1)) begin
      acc_d   = sample_ext;
      count_d = WLcnt'(1);
    end else if (clr && !in_valid) begin
      acc_d   = '0;
      count_d = '0;
    end else if (in_valid && (count_q == LAST)) begin
      out_valid_d = 1'b1;
      out_data_d  = clr ? sample_ext : result_c;
      acc_d       = '0;
      count_d     = '0;
    end else if (in_valid) begin
      acc_d   = sum_c;
      count_d = count_q + WLcnt'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign acc_count = count_q;

endmodule

// File: tb/tb_signed_accum_dump.sv
// Bench for signed_accum_dump: sum (N=4), average (N=4) and N=1 instances share
// one stimulus stream and are checked every cycle against a block-list model.
module tb_signed_accum_dump;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clr = 1'b0;
  logic              in_valid = 1'b0;
  logic signed [3:0] in_data = '0;

  logic              s_valid, a_valid, o_valid;
  logic signed [5:0] s_data, a_data;
  logic signed [3:0] o_data;
  logic        [1:0] s_cnt, a_cnt;
  logic        [0:0] o_cnt;

  always #5 clk = ~clk;

  signed_accum_dump #(.WLin(4), .N_ACC(4), .MODE(0)) u_sum (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(s_valid), .out_data(s_data), .acc_count(s_cnt));

  signed_accum_dump #(.WLin(4), .N_ACC(4), .MODE(1)) u_avg (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(a_valid), .out_data(a_data), .acc_count(a_cnt));

  signed_accum_dump #(.WLin(4), .N_ACC(1), .MODE(0)) u_one (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(o_valid), .out_data(o_data), .acc_count(o_cnt));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int floor_div(input int s, input int n);
    int q;
    q = s / n;
    if ((s % n) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  // Model: list of samples in the current block; a full block of 4 dumps.
  int blk[$];
  bit m_valid = 0;
  int m_sum = 0, m_avg = 0;
  bit m1_valid = 0;
  int m1_data = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk.delete();
      m_valid = 0; m_sum = 0; m_avg = 0;
      m1_valid = 0; m1_data = 0;
    end else begin
      m_valid  = 0;
      m1_valid = 0;
      if (in_valid) begin
        m1_valid = 1;
        m1_data  = int'(in_data);
      end
      if (clr && in_valid) begin
        blk.delete();
        blk.push_back(int'(in_data));
      end else if (clr) begin
        blk.delete();
      end else if (in_valid) begin
        blk.push_back(int'(in_data));
        if (blk.size() == 4) begin
          int s;
          s = 0;
          foreach (blk[i]) s += blk[i];
          m_valid = 1;
          m_sum   = s;
          m_avg   = floor_div(s, 4);
          blk.delete();
        end
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    chk("sum.out_valid", int'(s_valid), int'(m_valid));
    chk("sum.out_data",  int'(s_data),  m_sum);
    chk("sum.acc_count", int'(s_cnt),   blk.size());
    chk("avg.out_valid", int'(a_valid), int'(m_valid));
    chk("avg.out_data",  int'(a_data),  m_avg);
    chk("avg.acc_count", int'(a_cnt),   blk.size());
    chk("one.out_valid", int'(o_valid), int'(m1_valid));
    chk("one.out_data",  int'(o_data),  m1_data);
    chk("one.acc_count", int'(o_cnt),   0);
  end

  // Drive inputs for one edge; returns at the following negedge.
  task automatic step(input bit c, input bit v, input int d);
    clr      = c;
    in_valid = v;
    in_data  = 4'(d);
    @(negedge clk);
  endtask

  int cnt_exp[7] = '{1, 1, 1, 2, 3, 3, 0};
  int seq_v[7]   = '{1, 0, 0, 1, 1, 0, 1};
  int pulses;

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("reset out_valid", int'(s_valid), 0);
    chk("reset out_data",  int'(s_data),  0);
    chk("reset acc_count", int'(s_cnt),   0);
    rst_n = 1'b1;

    // Most-negative samples: full-precision sum without wrap.
    for (int i = 0; i < 4; i++) begin
      chk("neg no early pulse", int'(s_valid), 0);
      step(0, 1, -8);
    end
    chk("neg pulse",     int'(s_valid), 1);
    chk("neg sum",       int'(s_data),  -32);
    chk("neg avg",       int'(a_data),  -8);
    chk("neg count",     int'(s_cnt),   0);
    step(0, 0, 0);
    chk("neg pulse ends", int'(s_valid), 0);
    chk("neg data holds", int'(s_data),  -32);

    // Gaps between samples.
    for (int i = 0; i < 7; i++) begin
      step(0, seq_v[i] != 0, 7);
      chk("gap count", int'(s_cnt), cnt_exp[i]);
    end
    chk("gap sum", int'(s_data), 28);
    chk("gap avg", int'(a_data), 7);

    // Floor averaging.
    step(0, 1, 7); step(0, 1, 7); step(0, 1, 7); step(0, 1, 6);
    chk("avg 27/4", int'(a_data), 6);
    chk("sum 27",   int'(s_data), 27);
    step(0, 1, -1); step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
    chk("avg -1/4 floor", int'(a_data), -1);
    chk("avg pulse",      int'(a_valid), 1);

    // Clear without a sample.
    step(0, 1, 5); step(0, 1, 5);
    step(1, 0, 0);
    chk("clr count", int'(s_cnt), 0);
    step(0, 1, 1); step(0, 1, 1); step(0, 1, 1); step(0, 1, 1);
    chk("clr sum", int'(s_data), 4);

    // Clear with the would-be 4th sample restarts the block.
    step(0, 1, 1); step(0, 1, 1); step(0, 1, 1);
    step(1, 1, 3);
    chk("clr+v no pulse", int'(s_valid), 0);
    chk("clr+v count",    int'(s_cnt),   1);
    chk("clr+v data held", int'(s_data), 4);
    chk("n1 clr+v pulse", int'(o_valid), 1);
    chk("n1 clr+v data",  int'(o_data),  3);
    step(0, 1, 1); step(0, 1, 1); step(0, 1, 1);
    chk("clr+v sum", int'(s_data), 6);

    // Back-to-back dumps.
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 1);
      if (s_valid) pulses++;
      if (i == 3 || i == 7) chk("b2b pulse", int'(s_valid), 1);
      else                  chk("b2b no pulse", int'(s_valid), 0);
      if (i >= 3) chk("b2b data", int'(s_data), 4);
    end
    chk("b2b pulse count", pulses, 2);

    // Asynchronous reset mid-block.
    step(0, 1, 2); step(0, 1, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async out_valid", int'(s_valid), 0);
    chk("async out_data",  int'(s_data),  0);
    chk("async acc_count", int'(s_cnt),   0);
    chk("async n1 data",   int'(o_data),  0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 2); step(0, 1, 2); step(0, 1, 2); step(0, 1, 2);
    chk("post-reset sum", int'(s_data), 8);
    chk("post-reset avg", int'(a_data), 2);
    step(0, 0, 0);
    step(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/signed_accum_dump.md
Name: signed_accum_dump

Overview:
- Parameterised signed accumulate-and-dump block. It is the sequential successor to the team's full-precision signed two-input adder.
- Sums N_ACC valid signed samples at full precision with no overflow possible. It then presents the sum, or the floor-average, with a one-cycle valid pulse and restarts.
- Sits after sample sources such as ADC/filter stages, for decimation, averaging and block sums.

Parameters:
- WLin, 4, input sample width in bits (signed two's complement, >= 2).
- N_ACC, 4, samples per dump (>= 1).
- MODE, 0, output mode: 0 = full sum; 1 = average, arithmetic shift right by CLOG2(N_ACC). MODE=1 requires N_ACC to be a power of 2; elaboration fails otherwise.
- WLout, WLin + CLOG2(N_ACC), output width (derived, do not override). For N_ACC = 1, WLout = WLin.
- WLcnt, max(1, CLOG2(N_ACC)), sample-counter width (derived).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear; discards the partial accumulation.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  WLin  signed input sample.
- out_valid  output  1  one-cycle pulse; out_data holds a new result.
- out_data  output  WLout  signed result; holds its value until the next dump.
- acc_count  output  WLcnt  number of samples in the current partial accumulation, 0..N_ACC-1.

Behaviour:
- Reset (rst_n=0, asynchronous): acc=0, acc_count=0, out_valid=0, out_data=0. The first edge after rst_n rises is a normal operating edge.
- Internal acc is WLout bits signed. in_data is sign-extended to WLout before adding. No saturation or wrap can occur: |sum| <= N_ACC*2^(WLin-1), which fits in WLout bits.
- States are implied by acc_count: ACCUM (count 0..N_ACC-1). The dump is a transition, not a separate state.
- Each rising edge, highest priority first:
  - 1. clr=1 and in_valid=1: acc <= sext(in_data); acc_count <= 1. If N_ACC=1, this is instead a dump of in_data.
  - 2. clr=1 and in_valid=0: acc <= 0; acc_count <= 0.
  - 3. in_valid=1 and acc_count==N_ACC-1 (dump): out_data <= f(acc + sext(in_data)); out_valid <= 1; acc <= 0; acc_count <= 0.
  - 4. in_valid=1 otherwise: acc <= acc + sext(in_data); acc_count <= acc_count + 1.
  - 5. in_valid=0: acc and acc_count hold.
- out_valid is 0 on every edge that is not a dump. A dump never stalls, so back-to-back dumps are allowed; for N_ACC=1 every valid sample dumps.
- clr never affects out_data or a dump already registered. A clr coinciding with the Nth sample follows rule 1: the sample starts the new block and no dump occurs (unless N_ACC=1).
- f(): MODE 0 returns the sum unchanged. MODE 1 returns the sum arithmetically shifted right by CLOG2(N_ACC), sign-extended into WLout. Rounding is toward negative infinity.
- Latency: out_valid and out_data appear in the cycle immediately after the edge that accepts the Nth sample.
- Gaps: in_valid may be low for any number of cycles between samples with no effect on the result.
- Reset mid-block: the partial sum is lost, out_valid drops immediately, out_data goes to 0.

Test Plan:
- Reset release, MODE 0, WLin=4, N_ACC=4: feed -8,-8,-8,-8 on consecutive cycles -> one out_valid pulse one cycle after the 4th sample, out_data = -32 (6'b100000), acc_count back to 0.
- MODE 0: feed 7,_,_,7,7,_,7 (_ = in_valid low) -> out_data = 28 with a single pulse; acc_count reads 1,1,1,2,3,3,0.
- MODE 1, N_ACC=4: feed 7,7,7,6 -> out_data = 6. Then feed -1,0,0,0 -> out_data = -1 (floor, not 0).
- Clear: feed 5,5, then clr with in_valid=0, then 1,1,1,1 -> out_data = 4. Separately, clr with in_valid=1 (sample 3) on what would be the 4th sample -> no pulse, acc_count = 1, and the next three samples of 1 give out_data = 6.
- Back-to-back: continuous in_valid with 1 for 8 cycles -> two pulses 4 cycles apart, each out_data = 4; out_data holds 4 between pulses.
- Async reset: assert rst_n=0 mid-clock after 2 samples -> out_valid=0, out_data=0, acc_count=0 without waiting for an edge. Then 4 samples of 2 -> out_data = 8.
